// File: rtl/ac_motor_pkg.sv
// rtl/ac_motor_pkg.sv - shared types and defaults for the three-phase PWM modulator
package ac_motor_pkg;

    localparam int unsigned CNT_W_DEF  = 12;
    localparam int unsigned PHASES_DEF = 3;

    typedef enum logic {
        CAR_UP   = 1'b0,
        CAR_DOWN = 1'b1
    } car_dir_e;

endpackage

// File: rtl/ac_motor_pwm_carrier.sv
// rtl/ac_motor_pwm_carrier.sv - triangular up/down carrier with active period register
module ac_motor_pwm_carrier
    import ac_motor_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [CNT_W-1:0] pend_period_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] period_o,
    output car_dir_e         dir_o,
    output logic             at_bot_o,
    output logic             at_top_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    car_dir_e         dir_q, dir_d;
    logic [CNT_W-1:0] cnt_inc, cnt_dec;

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign cnt_dec = cnt_q - CNT_W'(1);

    // The direction register describes the value being entered, so the
    // apex cycle is already DOWN and the bottom cycle is always UP.
    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        period_d = period_q;
        if (cnt_q == '0) begin
            period_d = pend_period_i;
            if (pend_period_i == '0) begin
                cnt_d = '0;
                dir_d = CAR_UP;
            end else begin
                cnt_d = CNT_W'(1);
                dir_d = (pend_period_i == CNT_W'(1)) ? CAR_DOWN : CAR_UP;
            end
        end else if (dir_q == CAR_UP && cnt_q < period_q) begin
            cnt_d = cnt_inc;
            dir_d = (cnt_inc == period_q) ? CAR_DOWN : CAR_UP;
        end else begin
            cnt_d = cnt_dec;
            dir_d = (cnt_dec == '0) ? CAR_UP : CAR_DOWN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            period_q <= '0;
            dir_q    <= CAR_UP;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            dir_q    <= dir_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign period_o = period_q;
    assign dir_o    = dir_q;
    assign at_bot_o = (cnt_q == '0);
    assign at_top_o = (cnt_q == period_q) && (period_q != '0);

endmodule

// File: rtl/ac_motor_pwm_gen.sv
// rtl/ac_motor_pwm_gen.sv - three-phase center-aligned PWM with bottom-synchronous shadow registers
module ac_motor_pwm_gen
    import ac_motor_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned PHASES = PHASES_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    enable_i,
    input  logic                    load_i,
    input  logic [CNT_W-1:0]        period_i,
    input  logic [PHASES*CNT_W-1:0] duty_i,
    output logic [PHASES-1:0]       s_out_o,
    output logic                    sync_bot_o,
    output logic                    sync_top_o
);

    logic [CNT_W-1:0]        pend_period_q;
    logic [PHASES*CNT_W-1:0] pend_duty_q;
    logic [PHASES*CNT_W-1:0] act_duty_q;
    logic [PHASES-1:0]       s_out_q, s_out_d;
    logic                    sync_bot_q, sync_top_q;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_period;
    car_dir_e         dir;
    logic             at_bot;
    logic             at_top;

    ac_motor_pwm_carrier #(
        .CNT_W (CNT_W)
    ) u_carrier (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .pend_period_i (pend_period_q),
        .cnt_o         (cnt),
        .period_o      (act_period),
        .dir_o         (dir),
        .at_bot_o      (at_bot),
        .at_top_o      (at_top)
    );

    // UP counts strictly below D, DOWN includes D but excludes the bottom,
    // which yields exactly 2D high clocks centered on the carrier bottom.
    for (genvar g = 0; g < PHASES; g++) begin : g_phase
        logic [CNT_W-1:0] duty_raw;
        logic [CNT_W-1:0] duty_clamped;
        logic             cmp;

        assign duty_raw     = act_duty_q[g*CNT_W +: CNT_W];
        assign duty_clamped = (duty_raw > act_period) ? act_period : duty_raw;
        assign cmp          = (dir == CAR_UP) ? (cnt < duty_clamped)
                                              : ((cnt <= duty_clamped) && (cnt != '0));
        assign s_out_d[g]   = enable_i & cmp;
    end

    // The bottom copy reads pend_*_q, so a LOAD in that same cycle waits a period.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_period_q <= '0;
            pend_duty_q   <= '0;
            act_duty_q    <= '0;
            s_out_q       <= '0;
            sync_bot_q    <= 1'b0;
            sync_top_q    <= 1'b0;
        end else begin
            if (load_i) begin
                pend_period_q <= period_i;
                pend_duty_q   <= duty_i;
            end
            if (at_bot) begin
                act_duty_q <= pend_duty_q;
            end
            s_out_q    <= s_out_d;
            sync_bot_q <= at_bot;
            sync_top_q <= at_top;
        end
    end

    assign s_out_o    = s_out_q;
    assign sync_bot_o = sync_bot_q;
    assign sync_top_o = sync_top_q;

endmodule

// File: tb/tb_ac_motor_pwm_gen.sv
// tb/tb_ac_motor_pwm_gen.sv - scoreboard bench for the three-phase PWM modulator
module tb_ac_motor_pwm_gen;

    localparam int CW = 12;
    localparam int PH = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             load = 1'b0;
    logic [CW-1:0]    period = '0;
    logic [PH*CW-1:0] duty = '0;
    logic [PH-1:0]    s_out;
    logic             sync_bot;
    logic             sync_top;

    always #5 clk = ~clk;

    ac_motor_pwm_gen #(
        .CNT_W  (CW),
        .PHASES (PH)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .enable_i   (enable),
        .load_i     (load),
        .period_i   (period),
        .duty_i     (duty),
        .s_out_o    (s_out),
        .sync_bot_o (sync_bot),
        .sync_top_o (sync_top)
    );

    int tests_run = 0;
    int tests_failed = 0;
    logic [4:0] exp_q[$];

    // Reference model: phase index ph runs 0..2P-1, carrier = triangle of ph.
    int m_ph, m_P, p_P;
    int m_D[PH];
    int p_D[PH];

    task automatic check(input string name, input int act, input int req);
        tests_run++;
        if (act != req) begin
            tests_failed++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_ph = 0;
        m_P  = 0;
        p_P  = 0;
        for (int i = 0; i < PH; i++) begin
            m_D[i] = 0;
            p_D[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic [4:0] e;
        int dc;
        e = '0;
        if (!rst_n) begin
            model_reset();
            exp_q.push_back(e);
            return;
        end
        for (int i = 0; i < PH; i++) begin
            dc = (m_D[i] > m_P) ? m_P : m_D[i];
            e[i] = enable && (m_P != 0) && ((m_ph < dc) || (m_ph >= 2*m_P - dc));
        end
        e[3] = (m_ph == 0);
        e[4] = (m_P != 0) && (m_ph == m_P);
        exp_q.push_back(e);
        if (m_ph == 0) begin
            m_P = p_P;
            for (int i = 0; i < PH; i++) m_D[i] = p_D[i];
            m_ph = (m_P == 0) ? 0 : 1;
        end else begin
            m_ph = (m_ph + 1) % (2*m_P);
        end
        if (load) begin
            p_P = int'(period);
            for (int i = 0; i < PH; i++) p_D[i] = int'(duty[i*CW +: CW]);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    task automatic wait_bot();
        int k;
        k = 0;
        do begin
            step(1);
            k++;
        end while (!sync_bot && k < 40);
        check("wait_sync_bot", int'(sync_bot), 1);
    endtask

    task automatic count_window(input int n, output int c0, output int c1, output int c2,
                                output int cb, output int ct);
        c0 = 0; c1 = 0; c2 = 0; cb = 0; ct = 0;
        repeat (n) begin
            step(1);
            c0 += int'(s_out[0]);
            c1 += int'(s_out[1]);
            c2 += int'(s_out[2]);
            cb += int'(sync_bot);
            ct += int'(sync_top);
        end
    endtask

    always @(negedge clk) begin
        logic [4:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_top_bot_sout", int'({sync_top, sync_bot, s_out}), int'(e));
        end
    end

    initial begin
        int c0, c1, c2, cb, ct;
        model_reset();

        rst_n = 1'b0;
        step(2);
        check("reset_s_out", int'(s_out), 0);
        check("reset_sync_bot", int'(sync_bot), 0);
        check("reset_sync_top", int'(sync_top), 0);
        #2 rst_n = 1'b1;
        step(3);
        check("idle_sync_bot", int'(sync_bot), 1);

        // P=4, D={0,2,4}
        period = 12'd4;
        duty   = {12'd4, 12'd2, 12'd0};
        enable = 1'b1;
        load   = 1'b1;
        step(1);
        load = 1'b0;
        step(10);
        count_window(8, c0, c1, c2, cb, ct);
        check("p4_d0_high", c0, 0);
        check("p4_d2_high", c1, 4);
        check("p4_d4_high", c2, 8);
        check("p4_bot_cnt", cb, 1);
        check("p4_top_cnt", ct, 1);

        // mid-upslope duty change
        wait_bot();
        step(2);
        duty = {12'd4, 12'd2, 12'd1};
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(20);
        count_window(8, c0, c1, c2, cb, ct);
        check("d1_high", c0, 2);

        // LOAD in the bottom cycle
        wait_bot();
        step(7);
        duty = {12'd4, 12'd2, 12'd3};
        load = 1'b1;
        step(1);
        load = 1'b0;
        count_window(8, c0, c1, c2, cb, ct);
        check("bottom_load_old_duty", c0, 2);
        step(8);
        count_window(8, c0, c1, c2, cb, ct);
        check("bottom_load_new_duty", c0, 6);

        // clamp, then P=0
        duty = {12'd4, 12'd2, 12'd9};
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(20);
        count_window(8, c0, c1, c2, cb, ct);
        check("clamp_high", c0, 8);
        period = 12'd0;
        duty   = {12'd4, 12'd4, 12'd4};
        load   = 1'b1;
        step(1);
        load = 1'b0;
        step(20);
        count_window(5, c0, c1, c2, cb, ct);
        check("p0_bot_cnt", cb, 5);
        check("p0_top_cnt", ct, 0);
        check("p0_high", c0 + c1 + c2, 0);

        // P=5, ENABLE low for 3 cycles mid-pulse
        period = 12'd5;
        duty   = {12'd2, 12'd3, 12'd5};
        load   = 1'b1;
        step(1);
        load = 1'b0;
        step(3);
        wait_bot();
        step(1);
        enable = 1'b0;
        step(3);
        check("enable_low_s_out", int'(s_out), 0);
        enable = 1'b1;
        step(20);
        count_window(10, c0, c1, c2, cb, ct);
        check("p5_d5_high", c0, 10);
        check("p5_d3_high", c1, 6);
        check("p5_bot_cnt", cb, 1);

        // asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check("async_rst_s_out", int'(s_out), 0);
        check("async_rst_sync", int'({sync_top, sync_bot}), 0);
        step(2);
        #2 rst_n = 1'b1;
        step(2);
        count_window(4, c0, c1, c2, cb, ct);
        check("post_rst_bot_cnt", cb, 4);

        step(2);
        #10;
        check("queue_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
